// File: rtl/core_pkg.sv
// core_pkg: constants and types shared by the fetch stage and its interface.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
    typedef enum logic [1:0] {IDLE, WAIT, KILL} fetch_state_t;
endpackage

// File: rtl/ifetch_stage_if.sv
// ifetch_stage_if: instruction-memory request/response channel between fetch and memory.
interface ifetch_stage_if;
    import core_pkg::*;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [31:0]     resp_data;
    modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
    modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/ifid_skid_buf.sv
// ifid_skid_buf: one-entry holding buffer for a fetched instruction that decode cannot take yet.
module ifid_skid_buf
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc
);
    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    // A load in the same cycle as a drain refills the entry.
    always_comb begin
        valid_d = clear ? 1'b0 : load ? 1'b1 : drain ? 1'b0 : valid_q;
        instr_d = load ? instr_in : instr_q;
        pc_d    = load ? pc_in : pc_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end
    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: PC/fetch FSM with a single outstanding imem request, skid buffer and IF/ID register.
module ifetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic                  PcSrcE,
    input  logic [XLEN-1:0]       PCTargetE,
    ifetch_stage_if.master        imem,
    output logic [31:0]           InstrD,
    output logic [XLEN-1:0]       PCD,
    output logic [XLEN-1:0]       PCPlus4D,
    output logic                  ValidD,
    output logic [XLEN-1:0]       PCF
);
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d, req_pc_q, req_pc_d, pcd_q, pcd_d, pcp4_q, pcp4_d, buf_pc;
    logic [31:0]     instr_q, instr_d, buf_instr;
    logic            valid_q, valid_d, buf_valid;
    logic            resp_live, d_open, drain, to_d, buf_load, buf_free, fire;

    ifid_skid_buf u_buf (
        .clk(clk), .rst_n(rst_n), .load(buf_load), .drain(drain), .clear(PcSrcE),
        .instr_in(imem.resp_data), .pc_in(req_pc_q),
        .valid(buf_valid), .instr(buf_instr), .pc(buf_pc)
    );

    // Issue only when the buffer is guaranteed empty after this edge, so a response can never overflow it.
    always_comb begin
        resp_live      = state_q == WAIT && imem.resp_valid && !PcSrcE;
        d_open         = !FlushD && !StallD;
        drain          = d_open && buf_valid;
        to_d           = d_open && !buf_valid && resp_live;
        buf_load       = resp_live && !to_d;
        buf_free       = (!buf_valid || drain) && !buf_load;
        imem.req_valid = rst_n && !StallF && !PcSrcE && buf_free &&
                         (state_q == IDLE || (state_q == WAIT && imem.resp_valid));
        imem.req_addr  = {pcf_q[XLEN-1:2], 2'b00};
        fire           = imem.req_valid && imem.req_ready;
        pcf_d          = PcSrcE ? PCTargetE : fire ? pcf_q + 32'd4 : pcf_q;
        req_pc_d       = fire ? pcf_q : req_pc_q;
        state_d        = fire ? WAIT :
                         (state_q != IDLE && imem.resp_valid) ? IDLE :
                         (state_q == WAIT && PcSrcE) ? KILL : state_q;
    end

    always_comb begin
        instr_d = NOP_INSTR;
        pcd_d   = '0;
        pcp4_d  = '0;
        valid_d = 1'b0;
        if (!FlushD && StallD) begin
            instr_d = instr_q;
            pcd_d   = pcd_q;
            pcp4_d  = pcp4_q;
            valid_d = valid_q;
        end else if (drain) begin
            instr_d = buf_instr;
            pcd_d   = buf_pc;
            pcp4_d  = buf_pc + 32'd4;
            valid_d = 1'b1;
        end else if (to_d) begin
            instr_d = imem.resp_data;
            pcd_d   = req_pc_q;
            pcp4_d  = req_pc_q + 32'd4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pcf_q    <= RESET_PC;
            req_pc_q <= '0;
            instr_q  <= NOP_INSTR;
            pcd_q    <= '0;
            pcp4_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcf_q    <= pcf_d;
            req_pc_q <= req_pc_d;
            instr_q  <= instr_d;
            pcd_q    <= pcd_d;
            pcp4_q   <= pcp4_d;
            valid_q  <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;
    assign PCF      = pcf_q;

    resp_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem.resp_valid && state_q == IDLE));
endmodule
